// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: recovers BCD digits from a scanned 4-digit
// active-low 7-segment bus and flags bad patterns or a stalled scan.
module seg_scan_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg,
  input  logic [3:0]  an,
  output logic [15:0] bcd,
  output logic [3:0]  blank_mask,
  output logic        frame_valid,
  output logic        pattern_err,
  output logic        stalled
);

  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [0:0] HUNT    = 1'b0;
  localparam logic [0:0] COLLECT = 1'b1;
  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);

  logic [6:0] s_seg, p_seg;
  logic [3:0] s_an, p_an;
  logic [7:0] stab_cnt;
  logic [IW-1:0] idle_cnt;
  logic [0:0] state, st_n;
  logic [3:0] mask, mask_n;
  logic bad, bad_n, bad_acc;
  logic [3:0][3:0] sh_val, nx_val;
  logic [3:0] sh_blank, nx_blank;

  logic sel_ok;
  logic [1:0] dsel;
  logic same, cap, timeout_hit;
  logic wr, done;
  logic d_legal, d_blank;
  logic [3:0] d_val;

  // {legal, blank, value}; 0 = lit segment
  function automatic logic [5:0] decode(input logic [6:0] p);
    unique case (p)
      7'b0000001: decode = {2'b10, 4'h0};
      7'b1001111: decode = {2'b10, 4'h1};
      7'b0010010: decode = {2'b10, 4'h2};
      7'b0000110: decode = {2'b10, 4'h3};
      7'b1001100: decode = {2'b10, 4'h4};
      7'b0100100: decode = {2'b10, 4'h5};
      7'b0100000: decode = {2'b10, 4'h6};
      7'b0001111: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0001100: decode = {2'b10, 4'h9};
      7'b1111111: decode = {2'b11, 4'hF};
      default:    decode = {2'b00, 4'hF};
    endcase
  endfunction

  // Register the bus once and keep last cycle's sample for stability
  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg <= 7'h7F;
      s_an  <= 4'hF;
      p_seg <= 7'h7F;
      p_an  <= 4'hF;
    end else begin
      s_seg <= seg;
      s_an  <= an;
      p_seg <= s_seg;
      p_an  <= s_an;
    end
  end

  // Digit select, capture strobe and pattern decode
  always_comb begin
    sel_ok = 1'b0;
    dsel   = 2'd0;
    unique case (1'b1)
      (s_an == 4'b1110): begin sel_ok = 1'b1; dsel = 2'd0; end
      (s_an == 4'b1101): begin sel_ok = 1'b1; dsel = 2'd1; end
      (s_an == 4'b1011): begin sel_ok = 1'b1; dsel = 2'd2; end
      (s_an == 4'b0111): begin sel_ok = 1'b1; dsel = 2'd3; end
      default: ;
    endcase
    same = ({s_seg, s_an} == {p_seg, p_an});
    cap  = sel_ok && same && (stab_cnt == STAB_MAX - 8'd1);
    {d_legal, d_blank, d_val} = decode(s_seg);
    timeout_hit = !cap && (idle_cnt == IDLE_MAX - IW'(1));
  end

  // Frame assembly next-state
  always_comb begin
    st_n    = state;
    mask_n  = mask;
    bad_acc = bad;
    wr      = 1'b0;
    done    = 1'b0;
    if (cap) begin
      if (state == HUNT) begin
        if (dsel == 2'd0) begin
          wr      = 1'b1;
          mask_n  = 4'b0001;
          bad_acc = !d_legal;
          st_n    = COLLECT;
        end
      end else begin
        wr      = 1'b1;
        mask_n  = mask | (4'b0001 << dsel);
        bad_acc = bad | !d_legal;
        if (mask_n == 4'hF) begin
          done   = 1'b1;
          mask_n = 4'h0;
          st_n   = HUNT;
        end
      end
    end else if (timeout_hit) begin
      st_n    = HUNT;
      mask_n  = 4'h0;
      bad_acc = 1'b0;
    end
    bad_n    = done ? 1'b0 : bad_acc;
    nx_val   = sh_val;
    nx_blank = sh_blank;
    if (wr) begin
      nx_val[dsel]   = d_val;
      nx_blank[dsel] = d_blank;
    end
  end

  // Stability counter: restarts on change, clears when nothing selected
  always_ff @(posedge clk) begin
    if (reset)
      stab_cnt <= 8'd0;
    else if (!sel_ok)
      stab_cnt <= 8'd0;
    else if (!same)
      stab_cnt <= 8'd1;
    else if (stab_cnt != STAB_MAX)
      stab_cnt <= stab_cnt + 8'd1;
  end

  // Idle counter and stall flag
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else if (cap) begin
      idle_cnt <= '0;
      stalled  <= 1'b0;
    end else begin
      if (idle_cnt != IDLE_MAX)
        idle_cnt <= idle_cnt + IW'(1);
      if (timeout_hit)
        stalled <= 1'b1;
    end
  end

  // Frame FSM, shadows and published outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      mask        <= 4'h0;
      bad         <= 1'b0;
      sh_val      <= '0;
      sh_blank    <= 4'h0;
      bcd         <= 16'h0;
      blank_mask  <= 4'h0;
      frame_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      state       <= st_n;
      mask        <= mask_n;
      bad         <= bad_n;
      sh_val      <= nx_val;
      sh_blank    <= nx_blank;
      frame_valid <= done && !bad_acc;
      pattern_err <= cap && !d_legal;
      if (done && !bad_acc) begin
        bcd        <= nx_val;
        blank_mask <= nx_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scenarios for the
// 7-segment scan read-back decoder.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg = 7'h7F;
  logic [3:0]  an = 4'hF;
  logic [15:0] bcd;
  logic [3:0]  blank_mask;
  logic        frame_valid;
  logic        pattern_err;
  logic        stalled;

  seg_scan_decoder #(
    .STABLE_CYCLES(4),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg(seg),
    .an(an),
    .bcd(bcd),
    .blank_mask(blank_mask),
    .frame_valid(frame_valid),
    .pattern_err(pattern_err),
    .stalled(stalled)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int fv_cnt = 0;
  int pe_cnt = 0;
  int fv_cyc = -1;
  int pe_cyc = -1;
  int t2, t3;

  always @(negedge clk) begin
    if (frame_valid) begin
      fv_cnt <= fv_cnt + 1;
      fv_cyc <= cyc;
    end
    if (pattern_err) begin
      pe_cnt <= pe_cnt + 1;
      pe_cyc <= cyc;
    end
  end

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: pat = 7'b0000001;
      1: pat = 7'b1001111;
      2: pat = 7'b0010010;
      3: pat = 7'b0000110;
      4: pat = 7'b1001100;
      5: pat = 7'b0100100;
      6: pat = 7'b0100000;
      7: pat = 7'b0001111;
      8: pat = 7'b0000000;
      9: pat = 7'b0001100;
      default: pat = 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] anode(input int i);
    logic [3:0] one;
    one = 4'b0001;
    anode = ~(one << i);
  endfunction

  task automatic dwell(input logic [6:0] s, input logic [3:0] a,
                       input int n);
    seg = s;
    an  = a;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3);
    dwell(p0, anode(0), 8);
    dwell(p1, anode(1), 8);
    t2 = cyc;
    dwell(p2, anode(2), 8);
    t3 = cyc;
    dwell(p3, anode(3), 8);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bcd !== 16'h0) begin
      errors++;
      $display("FAIL reset_bcd got %h want 0000", bcd);
    end
    checks++;
    if (blank_mask !== 4'h0) begin
      errors++;
      $display("FAIL reset_blank got %b want 0000", blank_mask);
    end
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_fv got %b want 0", frame_valid);
    end
    checks++;
    if (pattern_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pe got %b want 0", pattern_err);
    end
    checks++;
    if (stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_stalled got %b want 0", stalled);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_normal();
    int fv0, pe0;
    fv0 = fv_cnt;
    pe0 = pe_cnt;
    frame(pat(1), pat(2), pat(3), pat(4));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL normal_fv_count got %0d want 1", fv_cnt - fv0);
    end
    checks++;
    if (fv_cyc !== t3 + 5) begin
      errors++;
      $display("FAIL normal_fv_cycle got %0d want %0d", fv_cyc, t3 + 5);
    end
    checks++;
    if (bcd !== 16'h4321) begin
      errors++;
      $display("FAIL normal_bcd got %h want 4321", bcd);
    end
    checks++;
    if (blank_mask !== 4'b0000) begin
      errors++;
      $display("FAIL normal_blank got %b want 0000", blank_mask);
    end
    checks++;
    if (pe_cnt !== pe0) begin
      errors++;
      $display("FAIL normal_pe got %0d want %0d", pe_cnt, pe0);
    end
  endtask

  task automatic test_blank_glitch();
    int fv0, pe0;
    logic [6:0] p [4];
    fv0 = fv_cnt;
    pe0 = pe_cnt;
    p[0] = pat(1);
    p[1] = pat(2);
    p[2] = pat(3);
    p[3] = 7'b1111111;
    for (int i = 0; i < 4; i++) begin
      dwell(7'b0000000, anode(i), 2);
      if (i == 3) t3 = cyc;
      dwell(p[i], anode(i), 8);
    end
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL glitch_fv_count got %0d want 1", fv_cnt - fv0);
    end
    checks++;
    if (fv_cyc !== t3 + 5) begin
      errors++;
      $display("FAIL glitch_fv_cycle got %0d want %0d", fv_cyc, t3 + 5);
    end
    checks++;
    if (bcd !== 16'hF321) begin
      errors++;
      $display("FAIL glitch_bcd got %h want f321", bcd);
    end
    checks++;
    if (blank_mask !== 4'b1000) begin
      errors++;
      $display("FAIL glitch_blank got %b want 1000", blank_mask);
    end
    checks++;
    if (pe_cnt !== pe0) begin
      errors++;
      $display("FAIL glitch_pe got %0d want %0d", pe_cnt, pe0);
    end
  endtask

  task automatic test_illegal();
    int fv0, pe0;
    fv0 = fv_cnt;
    pe0 = pe_cnt;
    frame(pat(1), pat(2), 7'b1111110, pat(3));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (pe_cnt - pe0 !== 1) begin
      errors++;
      $display("FAIL illegal_pe_count got %0d want 1", pe_cnt - pe0);
    end
    checks++;
    if (pe_cyc !== t2 + 5) begin
      errors++;
      $display("FAIL illegal_pe_cycle got %0d want %0d", pe_cyc, t2 + 5);
    end
    checks++;
    if (fv_cnt !== fv0) begin
      errors++;
      $display("FAIL illegal_fv got %0d want %0d", fv_cnt, fv0);
    end
    checks++;
    if (bcd !== 16'hF321) begin
      errors++;
      $display("FAIL illegal_bcd_kept got %h want f321", bcd);
    end
    frame(pat(5), pat(6), pat(7), pat(9));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL clean_fv_count got %0d want 1", fv_cnt - fv0);
    end
    checks++;
    if (bcd !== 16'h9765 || blank_mask !== 4'b0000) begin
      errors++;
      $display("FAIL clean_bcd got %h/%b want 9765/0000", bcd, blank_mask);
    end
  endtask

  task automatic test_mid_start();
    int fv0;
    reset = 1'b1;
    dwell(pat(7), anode(2), 3);
    reset = 1'b0;
    fv0 = fv_cnt;
    dwell(pat(7), anode(2), 8);
    dwell(pat(8), anode(3), 8);
    checks++;
    if (fv_cnt !== fv0 || bcd !== 16'h0) begin
      errors++;
      $display("FAIL midstart_ignored got fv %0d bcd %h want 0 0000",
               fv_cnt - fv0, bcd);
    end
    frame(pat(4), pat(3), pat(2), pat(1));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1) begin
      errors++;
      $display("FAIL midstart_fv_count got %0d want 1", fv_cnt - fv0);
    end
    checks++;
    if (fv_cyc !== t3 + 5) begin
      errors++;
      $display("FAIL midstart_fv_cycle got %0d want %0d", fv_cyc, t3 + 5);
    end
    checks++;
    if (bcd !== 16'h1234) begin
      errors++;
      $display("FAIL midstart_bcd got %h want 1234", bcd);
    end
  endtask

  task automatic test_stall();
    int t1, ts, fv0;
    dwell(pat(5), anode(0), 8);
    t1 = cyc;
    dwell(pat(5), anode(1), 8);
    seg = 7'h7F;
    an  = 4'hF;
    do @(negedge clk); while (cyc < t1 + 36);
    checks++;
    if (stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_early got %b want 0", stalled);
    end
    @(negedge clk);
    checks++;
    if (stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_assert got %b want 1", stalled);
    end
    checks++;
    if (bcd !== 16'h1234) begin
      errors++;
      $display("FAIL stall_bcd_kept got %h want 1234", bcd);
    end
    @(posedge clk);
    #1;
    fv0 = fv_cnt;
    ts = cyc;
    dwell(pat(8), anode(2), 3);
    checks++;
    if (stalled !== 1'b1) begin
      errors++;
      $display("FAIL stall_hold got %b want 1 at %0d", stalled, cyc - ts);
    end
    dwell(pat(8), anode(2), 5);
    checks++;
    if (stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_clear got %b want 0", stalled);
    end
    dwell(pat(8), anode(3), 8);
    checks++;
    if (fv_cnt !== fv0) begin
      errors++;
      $display("FAIL stall_partial_dropped got %0d want 0", fv_cnt - fv0);
    end
    frame(pat(0), pat(9), pat(0), pat(9));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1 || bcd !== 16'h9090) begin
      errors++;
      $display("FAIL stall_resume got fv %0d bcd %h want 1 9090",
               fv_cnt - fv0, bcd);
    end
  endtask

  task automatic test_reset_mid();
    int fv0;
    dwell(pat(1), anode(0), 8);
    dwell(pat(2), anode(1), 8);
    dwell(pat(3), anode(2), 2);
    reset = 1'b1;
    dwell(pat(3), anode(2), 3);
    checks++;
    if (bcd !== 16'h0 || blank_mask !== 4'h0 || frame_valid !== 1'b0 ||
        pattern_err !== 1'b0 || stalled !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_outputs got %h %b %b %b %b want 0",
               bcd, blank_mask, frame_valid, pattern_err, stalled);
    end
    reset = 1'b0;
    fv0 = fv_cnt;
    dwell(pat(3), anode(2), 8);
    dwell(pat(4), anode(3), 8);
    checks++;
    if (fv_cnt !== fv0 || bcd !== 16'h0) begin
      errors++;
      $display("FAIL rstmid_discard got fv %0d bcd %h want 0 0000",
               fv_cnt - fv0, bcd);
    end
    frame(pat(6), pat(7), pat(8), pat(9));
    dwell(7'h7F, 4'hF, 2);
    checks++;
    if (fv_cnt - fv0 !== 1 || bcd !== 16'h9876) begin
      errors++;
      $display("FAIL rstmid_fresh got fv %0d bcd %h want 1 9876",
               fv_cnt - fv0, bcd);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_blank_glitch();
    test_illegal();
    test_mid_start();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Reads back a 4-digit, time-multiplexed, active-low 7-segment display bus (segment lines plus anode enables) and recovers the BCD digits being shown. This is the inverse of our digit-to-segment encoding. It sits beside the display driver of the step-count display as a self-check and monitor: it confirms that what is scanned out matches the value the counter intends to show. It filters scan transitions with a stability counter, assembles complete frames, and flags illegal patterns and a stalled scan.

## Interface
- STABLE_CYCLES, 4: consecutive identical sampled cycles required before a digit is captured. Legal range 2..255.
- TIMEOUT_CYCLES, 65536: cycles without any capture before `stalled` asserts. Legal range ≥ 16.
- clk  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- seg  in  7  segment lines, active-low, bit6 = a … bit0 = g.
- an  in  4  anode enables, active-low; an[i] = 0 selects digit i.
- bcd  out  16  last good frame; digit i occupies bcd[4i+3:4i]; a blank digit reads 4'hF.
- blank_mask  out  4  bit i = 1 means digit i was blank in the last good frame.
- frame_valid  out  1  one-cycle pulse when `bcd` and `blank_mask` update.
- pattern_err  out  1  one-cycle pulse when an illegal segment pattern is captured.
- stalled  out  1  level; the scan has stopped (timeout).

## Operation
- **Input stage.** `seg` and `an` are registered once (s_seg, s_an) before any use.
- **Digit select.** s_an must be one-hot-low (1110, 1101, 1011, 0111) to select digit 0, 1, 2 or 3. Any other value (1111, or several anodes low) selects nothing: the stability counter is forced to 0 and no capture happens.
- **Stability counter stab_cnt (8 bit).**
  - A digit is selected and {s_seg, s_an} equals the previous cycle's value: stab_cnt increments, saturating at STABLE_CYCLES.
  - A digit is selected and the value differs from the previous cycle: stab_cnt loads 1.
  - A capture fires on the cycle stab_cnt transitions to STABLE_CYCLES. It fires exactly once per dwell, however long the dwell lasts.
- **Decode** (0 = lit):
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7, 0000000=8, 0001100=9.
  - 1111111 = blank, stored as 4'hF with its blank bit set.
  - Any other pattern is illegal: pattern_err pulses and the frame is marked bad.
- **FSM, two states.**
  - HUNT (reset state): captures of digits 1–3 are ignored. A capture of digit 0 stores into shadow digit 0, sets collect_mask = 0001, sets bad according to legality, and moves to COLLECT.
  - COLLECT: a capture of digit i writes shadow i and sets mask bit i. A repeat capture of the same digit overwrites the shadow (latest wins). An illegal capture sets bad.
  - COLLECT completion: when mask = 1111 and bad = 0, copy the shadows to bcd/blank_mask, pulse frame_valid, clear mask and bad, and return to HUNT. When mask = 1111 and bad = 1, do not update and do not pulse; clear mask and bad, and return to HUNT.
- **Idle counter.**
  - Clears on every capture; otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES: stalled = 1, FSM forced to HUNT, mask and bad cleared. bcd is retained.
  - stalled deasserts on the cycle of the next capture.
- **Reset values.** bcd = 0, blank_mask = 0, frame_valid = 0, pattern_err = 0, stalled = 0. Internally: FSM = HUNT, stab_cnt = 0, idle counter = 0, mask = 0, bad = 0. Reset during COLLECT discards the partial frame.

## Timing
- A pattern first present on the inputs at cycle t is sampled at t+1. Its capture fires at t+STABLE_CYCLES, provided the inputs are unchanged throughout.
- Output latency:
  - frame_valid, bcd and blank_mask update at t+STABLE_CYCLES+1, where t is the cycle the completing digit (the last to set its mask bit) first appears.
  - pattern_err pulses at the same offset, relative to the illegal digit.
- Minimum dwell for a capture is STABLE_CYCLES cycles. A shorter dwell (glitch or ghost) is never captured.
- If pattern_err and frame_valid coincide, the frame is bad and only pattern_err pulses.
- stalled asserts exactly TIMEOUT_CYCLES+1 cycles after the cycle of the last capture.

## Test plan
- **Normal frame.** STABLE_CYCLES = 4. Scan digits 0..3 with patterns for 1, 2, 3, 4, 8 cycles each. Expect frame_valid once, at cycle 4+1 after digit 3 appears; bcd = 16'h4321; blank_mask = 0000.
- **Blank and glitch.** Digit 3 shows 1111111. A 2-cycle ghost pattern 0000000 precedes each digit. Expect bcd = 16'hF321, blank_mask = 1000, and no capture of any ghost.
- **Illegal pattern.** Digit 2 shows 1111110. Expect pattern_err to pulse once, no frame_valid for that frame, bcd unchanged. The next clean frame updates normally.
- **Mid-frame start.** Release from reset with the scan at digit 2. Expect digits 2 and 3 to be ignored and the first frame_valid only after a full 0–3 sequence.
- **Stall.** TIMEOUT_CYCLES = 32. Hold an = 1111. Expect stalled = 1 at cycle 33 after the last capture. Resuming the scan clears stalled on the first capture.
- **Reset mid-frame.** Assert reset after digits 0–1 are captured. Expect all outputs 0 and no frame_valid until a fresh complete frame.
